// File: rtl/d3s_phase_tx_if.sv
// D3S phase stream bundle: ADC lanes and WR time in, timestamped phase words out.
// The master side is the transmit block; the slave side is its environment.
interface d3s_phase_tx_if;
    logic        enable_i;
    logic [13:0] ph0_i;
    logic [13:0] ph1_i;
    logic [13:0] ph2_i;
    logic [13:0] ph3_i;
    logic        tm_time_valid_i;
    logic [31:0] tm_tai_i;
    logic [27:0] tm_cycles_i;
    logic        phase_valid_o;
    logic [13:0] phase_o;
    logic [31:0] phase_ts_tai_o;
    logic [27:0] phase_ts_cycles_o;
    logic [31:0] sample_count_o;

    modport master (
        input  enable_i, ph0_i, ph1_i, ph2_i, ph3_i,
        input  tm_time_valid_i, tm_tai_i, tm_cycles_i,
        output phase_valid_o, phase_o, phase_ts_tai_o, phase_ts_cycles_o, sample_count_o
    );

    modport slave (
        output enable_i, ph0_i, ph1_i, ph2_i, ph3_i,
        output tm_time_valid_i, tm_tai_i, tm_cycles_i,
        input  phase_valid_o, phase_o, phase_ts_tai_o, phase_ts_cycles_o, sample_count_o
    );
endinterface

// File: rtl/d3s_phase_tx.sv
// D3S phase producer: averages 4-lane phase over WR-aligned windows of 2^g_decim_log2
// cycles, unwrapping around the window's first lane-0 sample, and emits one timestamped word per window.
module d3s_phase_tx #(
    parameter int g_decim_log2 = 4
) (
    input  logic           clk_i,
    input  logic           rst_i,
    d3s_phase_tx_if.master bus
);
    localparam int          ACC_W   = g_decim_log2 + 16;
    localparam int          SHIFT   = g_decim_log2 + 2;
    localparam logic [27:0] CYC_MAX = 28'd124999999;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SYNC = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    function automatic logic signed [15:0] f_offset(input logic [13:0] ph, input logic [13:0] ref_v);
        logic [13:0] d;
        d = ph - ref_v;
        return {{2{d[13]}}, d};
    endfunction

    function automatic logic [13:0] f_phase(input logic [13:0] ref_v, input logic signed [ACC_W-1:0] acc);
        return ref_v + 14'(acc >>> SHIFT);
    endfunction

    logic [1:0]  r_state;
    logic [27:0] r_prev_cyc;
    logic [13:0] r_ref;
    logic [31:0] r_tai;
    logic [27:0] r_cyc;

    logic        w_en_ok, w_aligned, w_end, w_jump, w_sync_like;
    logic        w_win, w_start, w_last;
    logic [13:0] w_ref;
    logic [31:0] w_tai;
    logic [27:0] w_cyc;
    logic signed [15:0] w_sum;

    logic        r_vld_p1, r_start_p1, r_last_p1;
    logic signed [15:0] r_s_p1;
    logic [13:0] r_ref_p1;
    logic [31:0] r_tai_p1;
    logic [27:0] r_cyc_p1;

    logic        r_vld_p2;
    logic signed [ACC_W-1:0] r_acc_p2;
    logic [13:0] r_ref_p2;
    logic [31:0] r_tai_p2;
    logic [27:0] r_cyc_p2;

    assign w_en_ok   = bus.enable_i && bus.tm_time_valid_i;
    assign w_aligned = (bus.tm_cycles_i[g_decim_log2-1:0] == '0);
    assign w_end     = &bus.tm_cycles_i[g_decim_log2-1:0];
    // A re-sync jump behaves like SYNC for this cycle so an aligned landing cycle starts a window at once.
    assign w_jump    = (r_state == ST_RUN) && (bus.tm_cycles_i != r_prev_cyc + 28'd1)
                       && !((r_prev_cyc == CYC_MAX) && (bus.tm_cycles_i == 28'd0));
    assign w_sync_like = (r_state == ST_SYNC) || w_jump;
    assign w_win     = w_en_ok && (((r_state == ST_RUN) && !w_jump) || (w_sync_like && w_aligned));
    assign w_start   = w_win && w_aligned;
    assign w_last    = w_win && w_end;

    assign w_ref = w_start ? bus.ph0_i : r_ref;
    assign w_tai = w_start ? bus.tm_tai_i : r_tai;
    assign w_cyc = w_start ? bus.tm_cycles_i : r_cyc;
    assign w_sum = f_offset(bus.ph0_i, w_ref) + f_offset(bus.ph1_i, w_ref)
                 + f_offset(bus.ph2_i, w_ref) + f_offset(bus.ph3_i, w_ref);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else if (!w_en_ok) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: r_state <= ST_SYNC;
                ST_SYNC: r_state <= w_aligned ? ST_RUN : ST_SYNC;
                ST_RUN:  if (w_jump && !w_aligned) r_state <= ST_SYNC;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        r_prev_cyc <= bus.tm_cycles_i;
        if (w_start) begin
            r_ref <= bus.ph0_i;
            r_tai <= bus.tm_tai_i;
            r_cyc <= bus.tm_cycles_i;
        end
    end

    // Stage 1: per-cycle lane offset sum
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_vld_p1   <= 1'b0;
            r_start_p1 <= 1'b0;
            r_last_p1  <= 1'b0;
        end else begin
            r_vld_p1   <= w_win;
            r_start_p1 <= w_start;
            r_last_p1  <= w_last;
        end
        r_s_p1   <= w_sum;
        r_ref_p1 <= w_ref;
        r_tai_p1 <= w_tai;
        r_cyc_p1 <= w_cyc;
    end

    // Stage 2: window accumulation
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_vld_p2 <= 1'b0;
        end else begin
            r_vld_p2 <= r_vld_p1 && r_last_p1;
        end
        if (r_vld_p1) begin
            r_acc_p2 <= r_start_p1 ? {{g_decim_log2{r_s_p1[15]}}, r_s_p1}
                                   : r_acc_p2 + {{g_decim_log2{r_s_p1[15]}}, r_s_p1};
        end
        if (r_vld_p1 && r_last_p1) begin
            r_ref_p2 <= r_ref_p1;
            r_tai_p2 <= r_tai_p1;
            r_cyc_p2 <= r_cyc_p1;
        end
    end

    // Output stage: outputs hold except in the strobe cycle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bus.phase_valid_o     <= 1'b0;
            bus.phase_o           <= '0;
            bus.phase_ts_tai_o    <= '0;
            bus.phase_ts_cycles_o <= '0;
            bus.sample_count_o    <= '0;
        end else begin
            bus.phase_valid_o <= r_vld_p2;
            if (r_vld_p2) begin
                bus.phase_o           <= f_phase(r_ref_p2, r_acc_p2);
                bus.phase_ts_tai_o    <= r_tai_p2;
                bus.phase_ts_cycles_o <= r_cyc_p2;
                bus.sample_count_o    <= bus.sample_count_o + 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_d3s_phase_tx.sv
// Scoreboard bench for d3s_phase_tx: three instances (g_decim_log2 = 1, 2, 3) share stimulus,
// only the selected one is enabled; expected words carry their required arrival cycle.
module tb_d3s_phase_tx;
    logic        clk = 1'b0;
    logic        rst, en, tval;
    logic [1:0]  sel;
    logic [31:0] tai;
    logic [27:0] cyc;
    logic [13:0] p0, p1, p2, p3;

    always #4 clk = ~clk;

    int tb_cyc = 0;
    always @(posedge clk) tb_cyc <= tb_cyc + 1;

    int checks = 0;
    int errors = 0;
    int cur_k  = 0;

    typedef struct {
        logic [13:0] ph;
        logic [31:0] tai;
        logic [27:0] cy;
        logic [31:0] cnt;
        int          at;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];
    int cnt_a = 0, cnt_b = 0, cnt_c = 0;

    d3s_phase_tx_if if_a();
    d3s_phase_tx_if if_b();
    d3s_phase_tx_if if_c();

    assign if_a.enable_i = en && (sel == 2'd0);
    assign if_b.enable_i = en && (sel == 2'd1);
    assign if_c.enable_i = en && (sel == 2'd2);
    assign if_a.ph0_i = p0; assign if_a.ph1_i = p1; assign if_a.ph2_i = p2; assign if_a.ph3_i = p3;
    assign if_b.ph0_i = p0; assign if_b.ph1_i = p1; assign if_b.ph2_i = p2; assign if_b.ph3_i = p3;
    assign if_c.ph0_i = p0; assign if_c.ph1_i = p1; assign if_c.ph2_i = p2; assign if_c.ph3_i = p3;
    assign if_a.tm_time_valid_i = tval; assign if_a.tm_tai_i = tai; assign if_a.tm_cycles_i = cyc;
    assign if_b.tm_time_valid_i = tval; assign if_b.tm_tai_i = tai; assign if_b.tm_cycles_i = cyc;
    assign if_c.tm_time_valid_i = tval; assign if_c.tm_tai_i = tai; assign if_c.tm_cycles_i = cyc;

    d3s_phase_tx #(.g_decim_log2(1)) u_a (.clk_i(clk), .rst_i(rst), .bus(if_a));
    d3s_phase_tx #(.g_decim_log2(2)) u_b (.clk_i(clk), .rst_i(rst), .bus(if_b));
    d3s_phase_tx #(.g_decim_log2(3)) u_c (.clk_i(clk), .rst_i(rst), .bus(if_c));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endtask

    task automatic cmp(input string nm, input exp_t e, input logic [13:0] ph, input logic [31:0] t,
                       input logic [27:0] c, input logic [31:0] n);
        chk({nm, " phase"}, 32'(ph), 32'(e.ph));
        chk({nm, " ts_tai"}, t, e.tai);
        chk({nm, " ts_cycles"}, 32'(c), 32'(e.cy));
        chk({nm, " sample_count"}, n, e.cnt);
        chk({nm, " arrival cycle"}, 32'(tb_cyc), 32'(e.at));
    endtask

    always @(negedge clk) begin
        if (if_a.phase_valid_o === 1'b1) begin
            checks++;
            if (q_a.size() == 0) begin
                errors++;
                $display("FAIL A strobe: got unexpected word phase=%0d ts_cycles=%0d, required none",
                         if_a.phase_o, if_a.phase_ts_cycles_o);
            end else begin
                cmp("A", q_a.pop_front(), if_a.phase_o, if_a.phase_ts_tai_o, if_a.phase_ts_cycles_o, if_a.sample_count_o);
            end
        end
    end

    always @(negedge clk) begin
        if (if_b.phase_valid_o === 1'b1) begin
            checks++;
            if (q_b.size() == 0) begin
                errors++;
                $display("FAIL B strobe: got unexpected word phase=%0d ts_cycles=%0d, required none",
                         if_b.phase_o, if_b.phase_ts_cycles_o);
            end else begin
                cmp("B", q_b.pop_front(), if_b.phase_o, if_b.phase_ts_tai_o, if_b.phase_ts_cycles_o, if_b.sample_count_o);
            end
        end
    end

    always @(negedge clk) begin
        if (if_c.phase_valid_o === 1'b1) begin
            checks++;
            if (q_c.size() == 0) begin
                errors++;
                $display("FAIL C strobe: got unexpected word phase=%0d ts_cycles=%0d, required none",
                         if_c.phase_o, if_c.phase_ts_cycles_o);
            end else begin
                cmp("C", q_c.pop_front(), if_c.phase_o, if_c.phase_ts_tai_o, if_c.phase_ts_cycles_o, if_c.sample_count_o);
            end
        end
    end

    task automatic cyc1(input logic r, input logic e, input logic [31:0] t, input logic [27:0] c,
                        input logic [13:0] a0, input logic [13:0] a1, input logic [13:0] a2, input logic [13:0] a3);
        @(posedge clk);
        #1;
        rst = r; en = e; tai = t; cyc = c;
        p0 = a0; p1 = a1; p2 = a2; p3 = a3;
        cur_k = tb_cyc;
    endtask

    task automatic push(input int s, input logic [13:0] ph, input logic [31:0] t, input logic [27:0] c);
        exp_t e;
        e.ph = ph; e.tai = t; e.cy = c; e.at = cur_k + 3;
        case (s)
            0: begin cnt_a++; e.cnt = 32'(cnt_a); q_a.push_back(e); end
            1: begin cnt_b++; e.cnt = 32'(cnt_b); q_b.push_back(e); end
            default: begin cnt_c++; e.cnt = 32'(cnt_c); q_c.push_back(e); end
        endcase
    endtask

    function automatic logic [13:0] ramp(input logic [27:0] c, input int k);
        longint v;
        v = 16 * (4 * longint'(c) + longint'(k));
        return v[13:0];
    endfunction

    initial begin
        rst = 1'b1; en = 1'b0; tval = 1'b1; sel = 2'd1;
        tai = '0; cyc = '0; p0 = '0; p1 = '0; p2 = '0; p3 = '0;

        // Reset state
        cyc1(1, 0, 0, 0, 0, 0, 0, 0);
        cyc1(1, 0, 0, 0, 0, 0, 0, 0);
        cyc1(0, 0, 0, 1, 0, 0, 0, 0);
        @(negedge clk);
        chk("reset B valid", 32'(if_b.phase_valid_o), 0);
        chk("reset B phase", 32'(if_b.phase_o), 0);
        chk("reset B ts_tai", if_b.phase_ts_tai_o, 0);
        chk("reset B ts_cycles", 32'(if_b.phase_ts_cycles_o), 0);
        chk("reset B count", if_b.sample_count_o, 0);
        chk("reset A valid", 32'(if_a.phase_valid_o), 0);
        chk("reset A count", if_a.sample_count_o, 0);
        chk("reset C valid", 32'(if_c.phase_valid_o), 0);
        chk("reset C count", if_c.sample_count_o, 0);

        // Constant lanes, g=2, time starts at cycle 5
        sel = 2'd1;
        for (int c = 5; c <= 19; c++) begin
            cyc1(0, 1, 3, 28'(c), 1000, 1000, 1000, 1000);
            if ((c % 4 == 3) && (c >= 11)) push(1, 1000, 3, 28'(c - 3));
        end
        for (int c = 20; c <= 24; c++) cyc1(0, 0, 3, 28'(c), 1000, 1000, 1000, 1000);

        // Ramp across a second boundary, window starting at cycle 0
        for (int i = 0; i < 15; i++) begin
            logic [27:0] c;
            c = (i < 2) ? 28'(124999998 + i) : 28'(i - 2);
            cyc1(0, i < 10, (i < 2) ? 4 : 5, c, ramp(c, 0), ramp(c, 1), ramp(c, 2), ramp(c, 3));
            if (c == 28'd3 && i < 10) push(1, 120, 5, 0);
            if (c == 28'd7 && i < 10) push(1, 376, 5, 4);
        end

        // TAI second rollover with no gap
        for (int i = 0; i < 19; i++) begin
            logic [27:0] c;
            logic [31:0] t;
            c = (i < 10) ? 28'(124999990 + i) : 28'(i - 10);
            t = (i < 10) ? 7 : 8;
            cyc1(0, i < 14, t, c, 100, 200, 300, 400);
            if (c == 28'd124999995) push(1, 250, 7, 124999992);
            if (c == 28'd124999999) push(1, 250, 7, 124999996);
            if (c == 28'd3 && i < 14) push(1, 250, 8, 0);
        end

        // One-cycle disable at window offset 2
        for (int c = 40; c <= 60; c++) begin
            logic [13:0] v;
            v = (c < 50) ? 14'd8000 : 14'd3000;
            cyc1(0, (c != 50) && (c < 56), 9, 28'(c), v, v, v, v);
            if (c == 47) push(1, 8000, 9, 44);
            if (c == 55) push(1, 3000, 9, 52);
        end

        // Reset at window offset 1
        for (int c = 60; c <= 64; c++) cyc1(0, 1, 9, 28'(c), 500, 500, 500, 500);
        cyc1(1, 1, 9, 65, 500, 500, 500, 500);
        cnt_a = 0; cnt_b = 0; cnt_c = 0;
        cyc1(0, 0, 9, 66, 500, 500, 500, 500);
        @(negedge clk);
        chk("mid-window reset valid", 32'(if_b.phase_valid_o), 0);
        chk("mid-window reset phase", 32'(if_b.phase_o), 0);
        chk("mid-window reset ts_tai", if_b.phase_ts_tai_o, 0);
        chk("mid-window reset ts_cycles", 32'(if_b.phase_ts_cycles_o), 0);
        chk("mid-window reset count", if_b.sample_count_o, 0);
        for (int c = 67; c <= 72; c++) cyc1(0, 0, 9, 28'(c), 500, 500, 500, 500);

        // Wrap-aware averaging, g=1
        sel = 2'd0;
        for (int c = 10; c <= 20; c++) begin
            if (c == 12 || c == 13)      cyc1(0, c < 16, 1, 28'(c), 16382, 2, 16382, 2);
            else if (c == 14 || c == 15) cyc1(0, c < 16, 1, 28'(c), 16383, 16383, 16383, 16383);
            else                         cyc1(0, c < 16, 1, 28'(c), 7, 7, 7, 7);
            if (c == 13) push(0, 0, 1, 12);
            if (c == 15) push(0, 16383, 1, 14);
        end

        // Time jump 100 -> 5000 while running, g=3
        sel = 2'd2;
        for (int i = 0; i < 30; i++) begin
            logic [27:0] c;
            c = (i <= 10) ? 28'(90 + i) : 28'(5000 + i - 11);
            if (c < 28'd5000)      cyc1(0, i < 27, 2, c, 12345, 12345, 12345, 12345);
            else if (c < 28'd5008) cyc1(0, i < 27, 2, c, 16000, 16100, 16200, 16300);
            else                   cyc1(0, i < 27, 2, c, 16300, 16350, 16380, 50);
            if (c == 28'd5007) push(2, 16150, 2, 5000);
            if (c == 28'd5015) push(2, 16366, 2, 5008);
        end
        for (int i = 0; i < 6; i++) cyc1(0, 0, 2, 28'(5020 + i), 0, 0, 0, 0);

        @(negedge clk);
        chk("A words outstanding", 32'(q_a.size()), 0);
        chk("B words outstanding", 32'(q_b.size()), 0);
        chk("C words outstanding", 32'(q_c.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/d3s_phase_tx.md
# d3s_phase_tx

Transmit-side producer of the D3S phase sample stream. Takes the 4-lane-per-cycle phase output of the ADC front end (lane 0 earliest). Averages it over a window of 2^g_decim_log2 clock cycles that is aligned to the White Rabbit cycle counter, with wrap-aware unwrapping. For each window it emits one timestamped 14-bit phase word on the phase_valid/phase/phase_ts interface consumed by the receive-side upsampler/divider. Runs on clk_wr_ref at 125 MHz; windows never straddle a TAI second.

## Interface

- g_decim_log2, default 4: window length is 2^g_decim_log2 cycles, i.e. 2^(g_decim_log2+2) samples. Legal range 1..6; 125e6 is divisible by 64, so aligned windows never cross a second boundary.
- clk_i  in  1  clk_wr_ref, 125 MHz; one clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- enable_i  in  1  stream enable; sampled every cycle.
- ph0_i, ph1_i, ph2_i, ph3_i  in  14 each  phase lanes for the current cycle, 0..16383 = 0..2π, modular.
- tm_time_valid_i  in  1  WR time valid.
- tm_tai_i  in  32  TAI seconds.
- tm_cycles_i  in  28  cycle counter, 0..124999999.
- phase_valid_o  out  1  one-cycle strobe per completed window.
- phase_o  out  14  window-average phase, modular.
- phase_ts_tai_o  out  32  TAI of the window's first cycle.
- phase_ts_cycles_o  out  28  tm_cycles of the window's first cycle; always a multiple of 2^g_decim_log2.
- sample_count_o  out  32  count of emitted words; wraps modulo 2^32.

## Operation

- Reset: all outputs 0 and state IDLE. Any pending window and accumulator are discarded.
- FSM:
  - IDLE → SYNC when enable_i && tm_time_valid_i.
  - SYNC → RUN on the first cycle with tm_cycles_i[g_decim_log2-1:0]==0. That cycle is the first window cycle.
  - RUN stays in RUN. Each cycle with low bits == 0 starts a new window, back-to-back.
  - Any state → IDLE on the cycle enable_i or tm_time_valid_i is sampled low. A partial window is dropped with no strobe. A window whose last cycle was already sampled still completes its output.
- Window start cycle:
  - latch ref = ph0_i, tm_tai_i and tm_cycles_i; clear the accumulator.
- Every window cycle, including the start:
  - offset_k = (ph_k_i − ref) mod 2^14, interpreted as two's complement in [−8192, 8191].
  - Stage 1 registers s = offset_0 + offset_1 + offset_2 + offset_3 (signed, 16 bits).
  - Stage 2 accumulates acc += s. acc is signed, g_decim_log2+16 bits; it cannot overflow.
- Window end:
  - mean = acc >>> (g_decim_log2+2), arithmetic shift, i.e. floor.
  - phase_o = (ref + mean) mod 2^14.
  - The timestamp outputs take the latched start values.
  - sample_count_o increments.
- phase_o and the timestamp outputs hold between strobes. They change only in the cycle phase_valid_o is high.
- Lanes spread more than ±8192 from ref alias. This is accepted, since input is band-limited.

## Timing

- The last window cycle's inputs are sampled at edge N. phase_valid_o is high for exactly the cycle after edge N+2, i.e. fixed latency 2.
- Strobe period in RUN: exactly 2^g_decim_log2 cycles, with no gaps at TAI second rollover (tm_cycles 124999999→0, tm_tai +1).
- From IDLE: the first strobe arrives 2 + 2^g_decim_log2 cycles after the first aligned cycle.
- Dropping enable_i at edge M, with M inside window W:
  - no strobe for W;
  - a strobe still occurs at M+1 or M+2 if the previous window's pipeline is in flight.
- tm_cycles jump (time re-sync) while in RUN: the current window is dropped and the FSM returns to SYNC. A jump is tm_cycles_i ≠ previous+1 and not the 124999999→0 rollover.
- rst_i mid-window: outputs are 0 on the next cycle and no strobe is issued for that window.

## Test plan

- Constant lanes: g_decim_log2=2, all lanes 1000, tm_cycles from 5 → first strobe for window at cycles 8, phase_o=1000, ts_cycles=8; then every 4 cycles with ts_cycles 12, 16…; sample_count_o increments each strobe.
- Wrap: lanes alternate 16382 and 2 (ph0=16382, ph1=2…), g_decim_log2=1 → phase_o=0; all lanes 16383 → phase_o=16383.
- Ramp: ph_k = 16·(4c+k) mod 16384 with c = tm_cycles, g_decim_log2=2, window start c=0 → phase_o=120 (floor of mean 120).
- Second rollover: g_decim_log2=2, tm_cycles 124999992→3 with tai 7→8 → strobes with (tai 7, cycles 124999992), (7, 124999996), (8, 0); period exactly 4.
- Mid-window disable: enable_i low for 1 cycle at window offset 2 → that window emits nothing; FSM resyncs; the next strobe is for the next aligned window after re-enable.
- Reset and time-jump: rst_i at window offset 1 → all outputs 0, no strobe; tm_cycles jump 100→5000 in RUN → the partial window is dropped and the next strobe has ts_cycles=5000 (g_decim_log2=3).
